tile_move_engine: RTL

TILE_MOVE_ENGINE -- requirements
Module: tile_move_engine

---
 rtl/game_pkg.sv | 42 ++++
 rtl/line_merge.sv | 71 +++++++
 rtl/tile_move_engine.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// ============================================================================
// Module      : game_pkg
// Description : Shared tile-board sizes, direction codes, move FSM states and
//               the line-to-cell index helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package game_pkg;

    localparam int DATA_W = 12;
    localparam int ROW    = 4;
    localparam int COL    = 4;

    localparam logic [1:0] DIR_LEFT  = 2'b00;
    localparam logic [1:0] DIR_RIGHT = 2'b01;
    localparam logic [1:0] DIR_UP    = 2'b10;
    localparam logic [1:0] DIR_DOWN  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PROC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Flat cell index 4*i+j of position p (destination-first) within line k.
    function automatic logic [3:0] cell_index(input logic [1:0] d,
                                              input logic [1:0] k,
                                              input logic [1:0] p);
        logic [3:0] idx;
        case (d)
            DIR_LEFT:  idx = {k, p};
            DIR_RIGHT: idx = {k, ~p};
            DIR_UP:    idx = {p, k};
            default:   idx = {~p, k};
        endcase
        return idx;
    endfunction

endpackage

`default_nettype wire

// File: rtl/line_merge.sv
// ============================================================================
// Module      : line_merge
// Description : Combinational compress-and-merge of one 4-cell line given
//               destination-first. Merge sum port only with TILE_MOVE_SCORE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module line_merge #(
    parameter int DATA_W = game_pkg::DATA_W
) (
    input  logic [3:0][DATA_W-1:0] line_in,
    output logic [3:0][DATA_W-1:0] line_out,
    output logic                   changed,
    output logic                   win
`ifdef TILE_MOVE_SCORE_EN
    ,
    output logic [15:0]            sum
`endif
);

    localparam logic [DATA_W-1:0] C_TILE_MAX = {1'b1, {(DATA_W-1){1'b0}}};

    logic [4:0][DATA_W-1:0] comp;
    logic [1:0]             n;
    logic [1:0]             m;
    logic                   skip;
    logic [DATA_W-1:0]      dbl;

    always_comb begin
        comp     = '0;
        n        = '0;
        line_out = '0;
        m        = '0;
        skip     = 1'b0;
        dbl      = '0;
        win      = 1'b0;
`ifdef TILE_MOVE_SCORE_EN
        sum      = '0;
`endif
        for (int k = 0; k < 4; k++) begin
            if (line_in[k] != '0) begin
                comp[n] = line_in[k];
                n       = n + 2'd1;
            end
        end
        // comp[4] stays zero so the last tile never finds a partner.
        for (int k = 0; k < 4; k++) begin
            if (skip) begin
                skip = 1'b0;
            end else if (comp[k] != '0) begin
                if ((comp[k] == comp[k+1]) && !comp[k][DATA_W-1]) begin
                    dbl         = {comp[k][DATA_W-2:0], 1'b0};
                    line_out[m] = dbl;
                    win         = win | (dbl == C_TILE_MAX);
`ifdef TILE_MOVE_SCORE_EN
                    sum         = sum + 16'(dbl);
`endif
                    skip        = 1'b1;
                end else begin
                    line_out[m] = comp[k];
                end
                m = m + 2'd1;
            end
        end
        changed = (line_out != line_in);
    end

endmodule

`default_nettype wire

// File: rtl/tile_move_engine.sv
// ============================================================================
// Module      : tile_move_engine
// Description : Applies one 2048-style move to a 4x4 board, one line per cycle
//               through a shared line_merge. TILE_MOVE_SCORE_EN adds score_add.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tile_move_engine #(
    parameter int DATA_W = game_pkg::DATA_W,
    parameter int ROW    = game_pkg::ROW,
    parameter int COL    = game_pkg::COL
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [1:0]                   dir,
    input  logic [ROW*COL*DATA_W-1:0]    board_in,
    output logic [ROW*COL*DATA_W-1:0]    board_out,
    output logic                         busy,
    output logic                         done,
    output logic                         moved,
    output logic                         win
`ifdef TILE_MOVE_SCORE_EN
    ,
    output logic [15:0]                  score_add
`endif
);

    localparam int C_NCELL = ROW * COL;

    game_pkg::state_e            state_q, state_d;
    logic [DATA_W-1:0]           cells_q [C_NCELL];
    logic [DATA_W-1:0]           cells_d [C_NCELL];
    logic [2:0]                  cnt_q, cnt_d;
    logic [1:0]                  dir_q, dir_d;
    logic                        moved_acc_q, moved_acc_d;
    logic                        win_acc_q, win_acc_d;
    logic [C_NCELL*DATA_W-1:0]   board_out_q, board_out_d;
    logic                        moved_q, moved_d;
    logic                        win_q, win_d;

    logic [3:0][3:0]             line_idx;
    logic [3:0][DATA_W-1:0]      line_in;
    logic [3:0][DATA_W-1:0]      line_out;
    logic                        line_changed;
    logic                        line_win;
`ifdef TILE_MOVE_SCORE_EN
    logic [15:0]                 line_sum;
    logic [15:0]                 score_acc_q, score_acc_d;
    logic [15:0]                 score_q, score_d;
`endif

    // Gather the current line destination-first from the working board.
    always_comb begin
        for (int p = 0; p < 4; p++) begin
            line_idx[p] = game_pkg::cell_index(dir_q, cnt_q[1:0], 2'(p));
            line_in[p]  = cells_q[line_idx[p]];
        end
    end

    line_merge #(
        .DATA_W   (DATA_W)
    ) u_line_merge (
        .line_in  (line_in),
        .line_out (line_out),
        .changed  (line_changed),
        .win      (line_win)
`ifdef TILE_MOVE_SCORE_EN
        ,
        .sum      (line_sum)
`endif
    );

    always_comb begin
        state_d     = state_q;
        cells_d     = cells_q;
        cnt_d       = cnt_q;
        dir_d       = dir_q;
        moved_acc_d = moved_acc_q;
        win_acc_d   = win_acc_q;
        board_out_d = board_out_q;
        moved_d     = moved_q;
        win_d       = win_q;
`ifdef TILE_MOVE_SCORE_EN
        score_acc_d = score_acc_q;
        score_d     = score_q;
`endif
        case (state_q)
            game_pkg::ST_IDLE: begin
                if (start) begin
                    for (int c = 0; c < C_NCELL; c++) begin
                        cells_d[c] = board_in[c*DATA_W +: DATA_W];
                    end
                    dir_d       = dir;
                    cnt_d       = '0;
                    moved_acc_d = 1'b0;
                    win_acc_d   = 1'b0;
`ifdef TILE_MOVE_SCORE_EN
                    score_acc_d = '0;
`endif
                    state_d     = game_pkg::ST_PROC;
                end
            end
            game_pkg::ST_PROC: begin
                // Counts 0..3 rewrite one line each; count 4 publishes the result.
                if (!cnt_q[2]) begin
                    for (int p = 0; p < 4; p++) begin
                        cells_d[line_idx[p]] = line_out[p];
                    end
                    moved_acc_d = moved_acc_q | line_changed;
                    win_acc_d   = win_acc_q | line_win;
`ifdef TILE_MOVE_SCORE_EN
                    score_acc_d = score_acc_q + line_sum;
`endif
                    cnt_d       = cnt_q + 3'd1;
                end else begin
                    for (int c = 0; c < C_NCELL; c++) begin
                        board_out_d[c*DATA_W +: DATA_W] = cells_q[c];
                    end
                    moved_d = moved_acc_q;
                    win_d   = win_acc_q;
`ifdef TILE_MOVE_SCORE_EN
                    score_d = score_acc_q;
`endif
                    state_d = game_pkg::ST_DONE;
                end
            end
            game_pkg::ST_DONE: begin
                state_d = game_pkg::ST_IDLE;
            end
            default: begin
                state_d = game_pkg::ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= game_pkg::ST_IDLE;
            for (int c = 0; c < C_NCELL; c++) begin
                cells_q[c] <= '0;
            end
            cnt_q       <= '0;
            dir_q       <= game_pkg::DIR_LEFT;
            moved_acc_q <= 1'b0;
            win_acc_q   <= 1'b0;
            board_out_q <= '0;
            moved_q     <= 1'b0;
            win_q       <= 1'b0;
`ifdef TILE_MOVE_SCORE_EN
            score_acc_q <= '0;
            score_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cells_q     <= cells_d;
            cnt_q       <= cnt_d;
            dir_q       <= dir_d;
            moved_acc_q <= moved_acc_d;
            win_acc_q   <= win_acc_d;
            board_out_q <= board_out_d;
            moved_q     <= moved_d;
            win_q       <= win_d;
`ifdef TILE_MOVE_SCORE_EN
            score_acc_q <= score_acc_d;
            score_q     <= score_d;
`endif
        end
    end

    assign busy      = (state_q != game_pkg::ST_IDLE);
    assign done      = (state_q == game_pkg::ST_DONE);
    assign board_out = board_out_q;
    assign moved     = moved_q;
    assign win       = win_q;
`ifdef TILE_MOVE_SCORE_EN
    assign score_add = score_q;
`endif

endmodule

`default_nettype wire
